// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state encoding, opcode/alu_sel codes and IR field helpers
package cpu_ctrl_pkg;

  // State encodings
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE = S_IDLE,
    ST_T0   = S_T0,
    ST_T1   = S_T1,
    ST_T2   = S_T2,
    ST_T3   = S_T3,
    ST_T4   = S_T4,
    ST_T5   = S_T5,
    ST_T6   = S_T6,
    ST_HALT = S_HALT
  } state_t;

  // Opcode values carried in the top OPC_W bits of IR
  localparam int OPC_ADD = 3;
  localparam int OPC_SUB = 4;
  localparam int OPC_AND = 5;
  localparam int OPC_OR  = 6;
  localparam int OPC_SHR = 7;
  localparam int OPC_SHL = 8;
  localparam int OPC_ROR = 9;
  localparam int OPC_ROL = 10;
  localparam int OPC_MUL = 15;
  localparam int OPC_DIV = 16;

  // ALU operation selects; 0 leaves the ALU idle
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SHR  = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_DIV  = 4'd10;

  // MSB of register field idx (0 = Ra, 1 = Rb, 2 = Rc, 3 = first unused bit)
  function automatic int field_msb(int word_w, int opc_w, int reg_w, int idx);
    return word_w - 1 - opc_w - idx * reg_w;
  endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// rtl/alu_instr_sequencer_if.sv - sequencer <-> datapath control bundle; MULDIV_EN adds Zhighout/HIin/LOin
interface alu_instr_sequencer_if #(
  parameter int WORD_W = 32,
  parameter int NREG   = 16
);
  logic              Run;
  logic              MemReady;
  logic [WORD_W-1:0] IR;
  logic              PCout, MARin, IncPC, Zin, Zlowout, PCin;
  logic              Read, MDRin, MDRout, IRin, Yin;
  logic [NREG-1:0]   Rin;
  logic [NREG-1:0]   Rout;
  logic [3:0]        alu_sel;
  logic              Done;
  logic              Illegal;
`ifdef MULDIV_EN
  logic              Zhighout, HIin, LOin;

  modport master (
    input  Run, MemReady, IR,
    output PCout, MARin, IncPC, Zin, Zlowout, PCin,
    output Read, MDRin, MDRout, IRin, Yin,
    output Rin, Rout, alu_sel, Done, Illegal,
    output Zhighout, HIin, LOin
  );

  modport slave (
    output Run, MemReady, IR,
    input  PCout, MARin, IncPC, Zin, Zlowout, PCin,
    input  Read, MDRin, MDRout, IRin, Yin,
    input  Rin, Rout, alu_sel, Done, Illegal,
    input  Zhighout, HIin, LOin
  );
`else
  modport master (
    input  Run, MemReady, IR,
    output PCout, MARin, IncPC, Zin, Zlowout, PCin,
    output Read, MDRin, MDRout, IRin, Yin,
    output Rin, Rout, alu_sel, Done, Illegal
  );

  modport slave (
    output Run, MemReady, IR,
    input  PCout, MARin, IncPC, Zin, Zlowout, PCin,
    input  Read, MDRin, MDRout, IRin, Yin,
    input  Rin, Rout, alu_sel, Done, Illegal
  );
`endif
endinterface

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational IR decode: legality, alu_sel, one-hot Ra/Rb/Rc; MULDIV_EN legalises MUL/DIV
module instr_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int NREG   = 16,
  parameter int REG_W  = $clog2(NREG),
  parameter int OPC_W  = 5
) (
  input  logic [WORD_W-1:0] ir,
  output logic              legal,
`ifdef MULDIV_EN
  output logic              muldiv,
`endif
  output logic [3:0]        alu_sel,
  output logic [NREG-1:0]   ra_oh,
  output logic [NREG-1:0]   rb_oh,
  output logic [NREG-1:0]   rc_oh
);

  localparam int RA_MSB  = field_msb(WORD_W, OPC_W, REG_W, 0);
  localparam int RB_MSB  = field_msb(WORD_W, OPC_W, REG_W, 1);
  localparam int RC_MSB  = field_msb(WORD_W, OPC_W, REG_W, 2);
  localparam int LOW_MSB = field_msb(WORD_W, OPC_W, REG_W, 3);
  localparam logic [REG_W:0] NREG_EXT = (REG_W + 1)'(NREG);

  logic [OPC_W-1:0] opc;
  logic [REG_W-1:0] ra, rb, rc;
  logic             op_ok, is_md;
  logic             ra_ok, rb_ok, rc_ok;
  logic             unused_ir_low;

  assign opc = ir[WORD_W-1 -: OPC_W];
  assign ra  = ir[RA_MSB -: REG_W];
  assign rb  = ir[RB_MSB -: REG_W];
  assign rc  = ir[RC_MSB -: REG_W];
  assign unused_ir_low = ^ir[LOW_MSB:0];

  // Index to one-hot; out-of-range indices give all zeros so Rin/Rout never over-select
  function automatic logic [NREG-1:0] onehot_dec(input logic [REG_W-1:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == REG_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign ra_oh = onehot_dec(ra);
  assign rb_oh = onehot_dec(rb);
  assign rc_oh = onehot_dec(rc);

  assign ra_ok = {1'b0, ra} < NREG_EXT;
  assign rb_ok = {1'b0, rb} < NREG_EXT;
  assign rc_ok = {1'b0, rc} < NREG_EXT;

  // Opcode table: recognised opcodes map to their alu_sel, everything else is illegal
  always_comb begin
    alu_sel = ALU_NONE;
    op_ok   = 1'b0;
    is_md   = 1'b0;
    case (opc)
      OPC_W'(OPC_ADD): begin alu_sel = ALU_ADD; op_ok = 1'b1; end
      OPC_W'(OPC_SUB): begin alu_sel = ALU_SUB; op_ok = 1'b1; end
      OPC_W'(OPC_AND): begin alu_sel = ALU_AND; op_ok = 1'b1; end
      OPC_W'(OPC_OR):  begin alu_sel = ALU_OR;  op_ok = 1'b1; end
      OPC_W'(OPC_SHR): begin alu_sel = ALU_SHR; op_ok = 1'b1; end
      OPC_W'(OPC_SHL): begin alu_sel = ALU_SHL; op_ok = 1'b1; end
      OPC_W'(OPC_ROR): begin alu_sel = ALU_ROR; op_ok = 1'b1; end
      OPC_W'(OPC_ROL): begin alu_sel = ALU_ROL; op_ok = 1'b1; end
`ifdef MULDIV_EN
      OPC_W'(OPC_MUL): begin alu_sel = ALU_MUL; op_ok = 1'b1; is_md = 1'b1; end
      OPC_W'(OPC_DIV): begin alu_sel = ALU_DIV; op_ok = 1'b1; is_md = 1'b1; end
`endif
      default: ;
    endcase
  end

  // MUL/DIV write HI/LO rather than a GP register, so Ra does not affect legality
  assign legal = op_ok && rb_ok && rc_ok && (is_md || ra_ok);

`ifdef MULDIV_EN
  assign muldiv = is_md;
`endif

endmodule

// File: rtl/alu_instr_sequencer.sv
// rtl/alu_instr_sequencer.sv - fetch/decode/execute control FSM for reg-reg ALU instructions; MULDIV_EN adds the T6 HI step
module alu_instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int NREG   = 16,
  parameter int REG_W  = $clog2(NREG),
  parameter int OPC_W  = 5
) (
  input logic                   Clock,
  input logic                   Reset,
  alu_instr_sequencer_if.master bus
);

  state_t          state, next_state;
  logic            t1_wait;
  logic            illegal_q;

  logic            dec_legal;
  logic [3:0]      dec_alu;
  logic [NREG-1:0] ra_oh, rb_oh, rc_oh;
`ifdef MULDIV_EN
  logic            dec_muldiv;
  logic            zhighout, hiin, loin;
`endif

  logic            pcout, marin, incpc, zin, zlowout, pcin;
  logic            read, mdrin, mdrout, irin, yin, done;
  logic [NREG-1:0] rin, rout;
  logic [3:0]      alu;

  instr_decoder #(
    .WORD_W (WORD_W),
    .NREG   (NREG),
    .REG_W  (REG_W),
    .OPC_W  (OPC_W)
  ) u_dec (
    .ir      (bus.IR),
    .legal   (dec_legal),
`ifdef MULDIV_EN
    .muldiv  (dec_muldiv),
`endif
    .alu_sel (dec_alu),
    .ra_oh   (ra_oh),
    .rb_oh   (rb_oh),
    .rc_oh   (rc_oh)
  );

  // State register, T1 wait marker (suppresses the one-shot PC update) and sticky illegal flag
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      t1_wait   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state   <= next_state;
      t1_wait <= (state == ST_T1) && !bus.MemReady;
      if (state == ST_T3 && !dec_legal) illegal_q <= 1'b1;
    end
  end

  // Next-state and Moore control decode; every control defaults low
  always_comb begin
    next_state = state;
    pcout   = 1'b0; marin = 1'b0; incpc  = 1'b0; zin  = 1'b0;
    zlowout = 1'b0; pcin  = 1'b0; read   = 1'b0; mdrin = 1'b0;
    mdrout  = 1'b0; irin  = 1'b0; yin    = 1'b0; done = 1'b0;
    rin     = '0;   rout  = '0;   alu    = ALU_NONE;
`ifdef MULDIV_EN
    zhighout = 1'b0; hiin = 1'b0; loin = 1'b0;
`endif
    case (state)
      ST_IDLE: if (bus.Run) next_state = ST_T0;
      ST_T0: begin
        pcout = 1'b1; marin = 1'b1; incpc = 1'b1; zin = 1'b1;
        next_state = ST_T1;
      end
      ST_T1: begin
        read    = 1'b1;
        mdrin   = 1'b1;
        zlowout = !t1_wait;
        pcin    = !t1_wait;
        if (bus.MemReady) next_state = ST_T2;
      end
      ST_T2: begin
        mdrout = 1'b1; irin = 1'b1;
        next_state = ST_T3;
      end
      ST_T3: begin
        if (dec_legal) begin
          rout = rb_oh; yin = 1'b1;
          next_state = ST_T4;
        end else begin
          next_state = ST_HALT;
        end
      end
      ST_T4: begin
        rout = rc_oh; alu = dec_alu; zin = 1'b1;
        next_state = ST_T5;
      end
      ST_T5: begin
        zlowout = 1'b1;
`ifdef MULDIV_EN
        if (dec_muldiv) begin
          loin = 1'b1;
          next_state = ST_T6;
        end else
`endif
        begin
          rin  = ra_oh;
          done = 1'b1;
          next_state = bus.Run ? ST_T0 : ST_IDLE;
        end
      end
`ifdef MULDIV_EN
      ST_T6: begin
        zhighout = 1'b1; hiin = 1'b1; done = 1'b1;
        next_state = bus.Run ? ST_T0 : ST_IDLE;
      end
`endif
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_IDLE;
    endcase
  end

  assign bus.PCout   = pcout;
  assign bus.MARin   = marin;
  assign bus.IncPC   = incpc;
  assign bus.Zin     = zin;
  assign bus.Zlowout = zlowout;
  assign bus.PCin    = pcin;
  assign bus.Read    = read;
  assign bus.MDRin   = mdrin;
  assign bus.MDRout  = mdrout;
  assign bus.IRin    = irin;
  assign bus.Yin     = yin;
  assign bus.Rin     = rin;
  assign bus.Rout    = rout;
  assign bus.alu_sel = alu;
  assign bus.Done    = done;
  assign bus.Illegal = illegal_q;
`ifdef MULDIV_EN
  assign bus.Zhighout = zhighout;
  assign bus.HIin     = hiin;
  assign bus.LOin     = loin;
`endif

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb/tb_alu_instr_sequencer.sv - scoreboard bench for alu_instr_sequencer; MULDIV_EN selects the MUL/DIV expectations
module tb_alu_instr_sequencer;

  logic Clock = 1'b0;
  logic Reset;

  always #5 Clock = ~Clock;

  alu_instr_sequencer_if #(.WORD_W(32), .NREG(16)) bus ();

  alu_instr_sequencer dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        pcout, marin, incpc, zin, zlowout, pcin;
    logic        read, mdrin, mdrout, irin, yin;
    logic [15:0] rin, rout;
    logic [3:0]  alu_sel;
    logic        done, illegal;
    logic        zhighout, hiin, loin;
  } ctl_t;

  ctl_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic ctl_t get_obs();
    ctl_t o;
    o = '0;
    o.pcout = bus.PCout;   o.marin = bus.MARin;     o.incpc = bus.IncPC;
    o.zin = bus.Zin;       o.zlowout = bus.Zlowout; o.pcin = bus.PCin;
    o.read = bus.Read;     o.mdrin = bus.MDRin;     o.mdrout = bus.MDRout;
    o.irin = bus.IRin;     o.yin = bus.Yin;
    o.rin = bus.Rin;       o.rout = bus.Rout;       o.alu_sel = bus.alu_sel;
    o.done = bus.Done;     o.illegal = bus.Illegal;
`ifdef MULDIV_EN
    o.zhighout = bus.Zhighout; o.hiin = bus.HIin; o.loin = bus.LOin;
`endif
    return o;
  endfunction

  function automatic ctl_t e_zero(input logic ill);
    ctl_t e;
    e = '0;
    e.illegal = ill;
    return e;
  endfunction

  // Expected T0, T1 (first + w wait cycles), T2
  task automatic push_fetch(input int w);
    ctl_t e;
    e = '0; e.pcout = 1; e.marin = 1; e.incpc = 1; e.zin = 1; exp_q.push_back(e);
    e = '0; e.zlowout = 1; e.pcin = 1; e.read = 1; e.mdrin = 1; exp_q.push_back(e);
    for (int k = 0; k < w; k++) begin
      e = '0; e.read = 1; e.mdrin = 1; exp_q.push_back(e);
    end
    e = '0; e.mdrout = 1; e.irin = 1; exp_q.push_back(e);
  endtask

  // Expected control vectors for a complete legal instruction
  task automatic push_instr(input logic [31:0] ir, input int w);
    ctl_t       e;
    logic [4:0] opc;
    logic [3:0] ra, rb, rc, alu;
    opc = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    case (opc)
      5'd3: alu = 4'd1;  5'd4: alu = 4'd2;  5'd5: alu = 4'd3;  5'd6: alu = 4'd4;
      5'd7: alu = 4'd5;  5'd8: alu = 4'd6;  5'd9: alu = 4'd7;  5'd10: alu = 4'd8;
      5'd15: alu = 4'd9; 5'd16: alu = 4'd10;
      default: alu = 4'd0;
    endcase
    push_fetch(w);
    e = '0; e.rout = 16'd1 << rb; e.yin = 1; exp_q.push_back(e);
    e = '0; e.rout = 16'd1 << rc; e.alu_sel = alu; e.zin = 1; exp_q.push_back(e);
    if (opc == 5'd15 || opc == 5'd16) begin
      e = '0; e.zlowout = 1; e.loin = 1; exp_q.push_back(e);
      e = '0; e.zhighout = 1; e.hiin = 1; e.done = 1; exp_q.push_back(e);
    end else begin
      e = '0; e.zlowout = 1; e.rin = 16'd1 << ra; e.done = 1; exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    ctl_t obs;
    Reset = 1; bus.Run = 0; bus.MemReady = 0; bus.IR = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      obs = get_obs(); n_checks++;
      if (obs !== e_zero(0)) $display("FAIL reset cyc%0d: got %h want %h", i, obs, e_zero(0));
      else n_pass++;
      if (i == 1) Reset = 0;
    end
  endtask

  task automatic test_and();
    ctl_t obs, want; int n;
    bus.IR = 32'h28918000; bus.MemReady = 0; bus.Run = 1;
    push_instr(32'h28918000, 0);
    exp_q.push_back(e_zero(0));
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      obs = get_obs(); want = exp_q.pop_front(); n_checks++;
      if (obs !== want) $display("FAIL and cyc%0d: got %h want %h", i, obs, want);
      else n_pass++;
      if (i == 1) bus.MemReady = 1;
      if (i == n - 2) bus.Run = 0;
    end
  endtask

  // Memory stalls 3 cycles; Run drops right after T0 and the instruction still completes
  task automatic test_mem_wait();
    ctl_t obs, want; int n;
    bus.IR = 32'h18918000; bus.MemReady = 0; bus.Run = 1;
    push_instr(32'h18918000, 3);
    exp_q.push_back(e_zero(0));
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      obs = get_obs(); want = exp_q.pop_front(); n_checks++;
      if (obs !== want) $display("FAIL mem_wait cyc%0d: got %h want %h", i, obs, want);
      else n_pass++;
      if (i == 0) bus.Run = 0;
      if (i == 4) bus.MemReady = 1;
    end
  endtask

  task automatic test_illegal();
    ctl_t obs, want; int n;
    bus.IR = 32'hF8000000; bus.MemReady = 0; bus.Run = 1;
    push_fetch(0);
    exp_q.push_back(e_zero(0));
    for (int k = 0; k < 6; k++) exp_q.push_back(e_zero(1));
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      obs = get_obs(); want = exp_q.pop_front(); n_checks++;
      if (obs !== want) $display("FAIL illegal cyc%0d: got %h want %h", i, obs, want);
      else n_pass++;
      if (i == 1) bus.MemReady = 1;
      if (i >= 3) bus.Run = ~bus.Run;
    end
    @(negedge Clock);
    Reset = 1; bus.Run = 0;
    #1;
    obs = get_obs(); n_checks++;
    if (obs !== e_zero(0)) $display("FAIL illegal_clear: got %h want %h", obs, e_zero(0));
    else n_pass++;
    @(negedge Clock);
    Reset = 0;
  endtask

  // Reset during the T1 wait, then during T4; a fresh instruction follows each release
  task automatic test_reset_mid();
    ctl_t obs, want; int n;
    int stop_at[2];
    int waits[2];
    stop_at[0] = 2; waits[0] = 5;
    stop_at[1] = 4; waits[1] = 0;
    for (int s = 0; s < 2; s++) begin
      bus.IR = 32'h18918000; bus.MemReady = 0; bus.Run = 1;
      push_instr(32'h18918000, waits[s]);
      for (int i = 0; i <= stop_at[s]; i++) begin
        @(negedge Clock);
        obs = get_obs(); want = exp_q.pop_front(); n_checks++;
        if (obs !== want) $display("FAIL reset_mid%0d cyc%0d: got %h want %h", s, i, obs, want);
        else n_pass++;
        if (i == 1 + waits[s]) bus.MemReady = 1;
      end
      exp_q.delete();
      Reset = 1;
      #1;
      obs = get_obs(); n_checks++;
      if (obs !== e_zero(0)) $display("FAIL reset_mid%0d async: got %h want %h", s, obs, e_zero(0));
      else n_pass++;
      @(negedge Clock);
      Reset = 0; bus.MemReady = 0;
      push_instr(32'h18918000, 0);
      exp_q.push_back(e_zero(0));
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
        @(negedge Clock);
        obs = get_obs(); want = exp_q.pop_front(); n_checks++;
        if (obs !== want) $display("FAIL reset_mid%0d resume cyc%0d: got %h want %h", s, i, obs, want);
        else n_pass++;
        if (i == 1) bus.MemReady = 1;
        if (i == n - 2) bus.Run = 0;
      end
    end
  endtask

  task automatic test_back_to_back();
    ctl_t obs, want; int n;
    logic [31:0] irs[2];
    irs[0] = 32'h18918000; irs[1] = 32'h1A2B0000;
    bus.IR = irs[0]; bus.MemReady = 1; bus.Run = 1;
    push_instr(irs[0], 0);
    push_instr(irs[1], 0);
    exp_q.push_back(e_zero(0));
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      obs = get_obs(); want = exp_q.pop_front(); n_checks++;
      if (obs !== want) $display("FAIL back_to_back cyc%0d: got %h want %h", i, obs, want);
      else n_pass++;
      if (i == 5) bus.IR = irs[1];
      if (i == n - 2) bus.Run = 0;
    end
  endtask

  // Every legal ALU opcode with random registers, streamed with Run held high
  task automatic test_alu_ops();
    ctl_t obs, want; int n;
    logic [31:0] irs[8];
    for (int k = 0; k < 8; k++) begin
      irs[k] = {5'(k + 3), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 15'd0};
      push_instr(irs[k], 0);
    end
    exp_q.push_back(e_zero(0));
    bus.IR = irs[0]; bus.MemReady = 1; bus.Run = 1;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      obs = get_obs(); want = exp_q.pop_front(); n_checks++;
      if (obs !== want) $display("FAIL alu_ops cyc%0d: got %h want %h", i, obs, want);
      else n_pass++;
      if (i % 6 == 5 && i / 6 < 7) bus.IR = irs[i / 6 + 1];
      if (i == n - 2) bus.Run = 0;
    end
  endtask

  task automatic test_muldiv();
    ctl_t obs, want; int n;
`ifdef MULDIV_EN
    bus.IR = 32'h78918000; bus.MemReady = 1; bus.Run = 1;
    push_instr(32'h78918000, 0);
    push_instr(32'h80918000, 0);
    exp_q.push_back(e_zero(0));
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      obs = get_obs(); want = exp_q.pop_front(); n_checks++;
      if (obs !== want) $display("FAIL muldiv cyc%0d: got %h want %h", i, obs, want);
      else n_pass++;
      if (i == 6) bus.IR = 32'h80918000;
      if (i == n - 2) bus.Run = 0;
    end
`else
    bus.IR = 32'h78918000; bus.MemReady = 1; bus.Run = 1;
    push_fetch(0);
    exp_q.push_back(e_zero(0));
    for (int k = 0; k < 3; k++) exp_q.push_back(e_zero(1));
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      obs = get_obs(); want = exp_q.pop_front(); n_checks++;
      if (obs !== want) $display("FAIL mul_illegal cyc%0d: got %h want %h", i, obs, want);
      else n_pass++;
    end
    Reset = 1; bus.Run = 0;
    #1;
    obs = get_obs(); n_checks++;
    if (obs !== e_zero(0)) $display("FAIL mul_illegal_clear: got %h want %h", obs, e_zero(0));
    else n_pass++;
    @(negedge Clock);
    Reset = 0;
`endif
  endtask

  initial begin
    test_reset();
    test_and();
    test_mem_wait();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_alu_ops();
    test_muldiv();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
